// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: FSM states, func3
// encodings, fault cause codes and store lane helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RESP  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

  function automatic logic load_func3_ok(input logic [2:0] f3);
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

  function automatic logic store_func3_ok(input logic [2:0] f3);
    return f3 inside {F3_SB, F3_SH, F3_SW};
  endfunction

  // size is func3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational read-lane select and sign/zero extension for loads.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (offset)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

    case (func3)
      F3_LB:   data = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  data = {24'd0, lane_b};
      F3_LH:   data = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  data = {16'd0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_sequencer.sv
// Stalls the core around one request/grant data-memory transaction per
// load/store, aligning read data and reporting misalign/illegal/timeout faults.
//
// state    | meaning
// IDLE     | waiting for a load/store; checks it and latches bus fields
// REQ      | bus_req held with constant address/data until bus_gnt
// RESP     | waiting for bus_rvalid (read data or write ack)
// DONE     | access retired; load_valid pulses for loads
// FAULT    | instruction retired without effect; fault pulses with cause
module load_store_sequencer
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_read_en,
  input  logic        data_mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TIMEOUT_TC = TIMEOUT[7:0];

  lsu_state_e  state;
  logic [7:0]  tmo_cnt;
  logic [7:0]  tmo_next;
  logic        tmo_hit;
  logic        op_valid;
  logic        op_illegal;
  logic        op_misaligned;
  logic [2:0]  func3_q;
  logic [1:0]  offset_q;
  logic        we_q;
  logic [31:0] aligned_data;

  assign op_valid      = mem_read_en | data_mem_write;
  assign op_misaligned = is_misaligned(func3[1:0], address[1:0]);
  assign tmo_next      = tmo_cnt + 8'd1;
  assign tmo_hit       = (tmo_next == TIMEOUT_TC);

  always_comb begin
    op_illegal = 1'b0;
    if (mem_read_en && data_mem_write) op_illegal = 1'b1;
    else if (data_mem_write)           op_illegal = !store_func3_ok(func3);
    else if (mem_read_en)              op_illegal = !load_func3_ok(func3);
  end

  // Gated by resetn so the core is released the instant reset asserts.
  assign stall = resetn & ((state == ST_REQ) || (state == ST_RESP) ||
                           ((state == ST_IDLE) && op_valid));

  // Aligns the word as it is captured so load_data holds until the next load.
  lsu_load_align u_load_align (
    .rdata  (bus_rdata),
    .func3  (func3_q),
    .offset (offset_q),
    .data   (aligned_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      func3_q     <= '0;
      offset_q    <= '0;
      we_q        <= 1'b0;
      load_data   <= '0;
      load_valid  <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_be      <= '0;
    end else begin
      load_valid  <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (op_valid) begin
            if (op_illegal) begin
              state       <= ST_FAULT;
              fault       <= 1'b1;
              fault_cause <= CAUSE_ILLEGAL;
            end else if (op_misaligned) begin
              state       <= ST_FAULT;
              fault       <= 1'b1;
              fault_cause <= CAUSE_MISALIGN;
            end else begin
              state     <= ST_REQ;
              func3_q   <= func3;
              offset_q  <= address[1:0];
              we_q      <= data_mem_write;
              bus_req   <= 1'b1;
              bus_we    <= data_mem_write;
              bus_addr  <= {address[31:2], 2'b00};
              bus_be    <= data_mem_write ? store_be(func3[1:0], address[1:0]) : 4'b1111;
              bus_wdata <= data_mem_write ? store_lanes(func3[1:0], store_data) : '0;
            end
          end
        end
        ST_REQ: begin
          tmo_cnt <= tmo_next;
          // Terminal count wins over a same-cycle grant: no budget left for RESP.
          if (tmo_hit || bus_gnt) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            if (tmo_hit) begin
              state       <= ST_FAULT;
              fault       <= 1'b1;
              fault_cause <= CAUSE_TIMEOUT;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          tmo_cnt <= tmo_next;
          if (bus_rvalid) begin
            state <= ST_DONE;
            if (!we_q) begin
              load_valid <= 1'b1;
              load_data  <= aligned_data;
            end
          end else if (tmo_hit) begin
            state       <= ST_FAULT;
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_FAULT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Vector-table bench for load_store_sequencer with a scoreboard of expected
// completions and a small bus responder; TIMEOUT is set to 4.
module tb_load_store_sequencer;

  localparam int TMO = 4;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          gnt_wait;
    int          rv_wait;
    bit          noise;
    logic [1:0]  cause;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          req_n;
    int          stall_n;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_read_en, data_mem_write;
  logic [2:0]  func3;
  logic [31:0] address, store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid, fault;
  logic [1:0]  fault_cause;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur      = 0;
  logic [31:0] last_load = '0;
  vec_t        sb_q[$];
  vec_t        tbl[19];

  always #5 clk = ~clk;

  load_store_sequencer #(.TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .mem_read_en(mem_read_en), .data_mem_write(data_mem_write),
    .func3(func3), .address(address), .store_data(store_data),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .fault(fault), .fault_cause(fault_cause),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL v%0d %s: got 0x%0h, expected 0x%0h", cur, name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rd, bit wr, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] sdata, logic [31:0] rdata, int gw, int rw,
                              bit noise, logic [1:0] cause, logic [31:0] data,
                              logic [3:0] be, logic [31:0] wdata, int req_n, int stall_n);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.gnt_wait = gw; v.rv_wait = rw; v.noise = noise; v.cause = cause; v.data = data;
    v.be = be; v.wdata = wdata; v.req_n = req_n; v.stall_n = stall_n;
    return v;
  endfunction

  task automatic drop_inputs();
    mem_read_en = 1'b0; data_mem_write = 1'b0; func3 = '0; address = '0; store_data = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t        e;
    int          n, stall_n, req_n, resp_n;
    bit          granted, busy, hold_bad;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;
    cur = idx;
    sb_q.push_back(v);
    @(negedge clk);
    mem_read_en = v.rd; data_mem_write = v.wr; func3 = v.f3;
    address = v.addr; store_data = v.sdata;
    #1;
    stall_n = stall ? 1 : 0;
    req_n = 0; resp_n = 0; granted = 0; busy = 1; hold_bad = 0; n = 0;
    c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h5A5A_5A5A;
      if (!stall) begin
        busy = 0;
      end else begin
        stall_n++;
        if (bus_req) begin
          if (req_n == 0) begin
            c_addr = bus_addr; c_wdata = bus_wdata; c_be = bus_be; c_we = bus_we;
          end else if (bus_addr !== c_addr || bus_wdata !== c_wdata ||
                       bus_be !== c_be || bus_we !== c_we) begin
            hold_bad = 1;
          end
          req_n++;
          if (v.gnt_wait >= 0 && req_n > v.gnt_wait) begin
            bus_gnt = 1'b1; granted = 1;
          end
          if (v.noise) bus_rvalid = 1'b1;
        end else if (granted) begin
          resp_n++;
          if (v.rv_wait >= 0 && resp_n > v.rv_wait) begin
            bus_rvalid = 1'b1; bus_rdata = v.rdata;
          end else if (v.noise) begin
            bus_gnt = 1'b1;
          end
        end
      end
    end
    e = sb_q.pop_front();
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL v%0d completion: still stalled after %0d cycles, expected end", idx, n);
    end
    chk("fault", 32'(fault), 32'(e.cause != 2'd0));
    chk("fault_cause", 32'(fault_cause), 32'(e.cause));
    chk("stall_cycles", stall_n, e.stall_n);
    chk("req_cycles", req_n, e.req_n);
    chk("bus_req_at_end", 32'(bus_req), 32'd0);
    if (e.req_n > 0) begin
      chk("bus_addr", c_addr, {e.addr[31:2], 2'b00});
      chk("bus_be", 32'(c_be), 32'(e.be));
      chk("bus_we", 32'(c_we), 32'(e.wr));
      if (e.wr) chk("bus_wdata", c_wdata, e.wdata);
      if (e.req_n > 1) chk("bus_hold", 32'(hold_bad), 32'd0);
    end
    if (e.cause == 2'd0 && e.rd) begin
      chk("load_valid", 32'(load_valid), 32'd1);
      chk("load_data", load_data, e.data);
      last_load = e.data;
    end else begin
      chk("load_valid", 32'(load_valid), 32'd0);
      chk("load_data_held", load_data, last_load);
    end
    drop_inputs();
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    chk("pulse_end", 32'({load_valid, fault, stall, bus_req}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    //                rd wr f3      addr          sdata          rdata         gw rw nz cause data           be      wdata          req stall
    tbl[0]  = mk(1, 0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 2'd0, 32'hDEAD_BEEF, 4'hF, 32'h0,         1, 3);
    tbl[1]  = mk(1, 0, 3'b000, 32'h0000_0103, 32'h0,         32'h8000_0000, 0, 0, 0, 2'd0, 32'hFFFF_FF80, 4'hF, 32'h0,         1, 3);
    tbl[2]  = mk(1, 0, 3'b100, 32'h0000_0103, 32'h0,         32'h8000_0000, 0, 0, 0, 2'd0, 32'h0000_0080, 4'hF, 32'h0,         1, 3);
    tbl[3]  = mk(1, 0, 3'b101, 32'h0000_0102, 32'h0,         32'hBEEF_0000, 0, 0, 0, 2'd0, 32'h0000_BEEF, 4'hF, 32'h0,         1, 3);
    tbl[4]  = mk(0, 1, 3'b001, 32'h0000_0206, 32'h1234_ABCD, 32'h0,         0, 0, 0, 2'd0, 32'h0,         4'hC, 32'hABCD_ABCD, 1, 3);
    tbl[5]  = mk(1, 0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,         0, 0, 0, 2'd1, 32'h0,         4'h0, 32'h0,         0, 1);
    tbl[6]  = mk(1, 0, 3'b111, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 0, 2'd2, 32'h0,         4'h0, 32'h0,         0, 1);
    tbl[7]  = mk(1, 0, 3'b001, 32'h0000_0102, 32'h0,         32'h8001_0000, 1, 0, 1, 2'd0, 32'hFFFF_8001, 4'hF, 32'h0,         2, 4);
    tbl[8]  = mk(0, 1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'h0,         0, 1, 1, 2'd0, 32'h0,         4'h2, 32'hA5A5_A5A5, 1, 4);
    tbl[9]  = mk(0, 1, 3'b010, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,         1, 0, 0, 2'd0, 32'h0,         4'hF, 32'hCAFE_F00D, 2, 4);
    tbl[10] = mk(0, 1, 3'b001, 32'h0000_0203, 32'h0000_1111, 32'h0,         0, 0, 0, 2'd1, 32'h0,         4'h0, 32'h0,         0, 1);
    tbl[11] = mk(0, 1, 3'b011, 32'h0000_0200, 32'h0,         32'h0,         0, 0, 0, 2'd2, 32'h0,         4'h0, 32'h0,         0, 1);
    tbl[12] = mk(1, 1, 3'b010, 32'h0000_0200, 32'h0,         32'h0,         0, 0, 0, 2'd2, 32'h0,         4'h0, 32'h0,         0, 1);
    tbl[13] = mk(1, 0, 3'b001, 32'h0000_0100, 32'h0,         32'h1234_F00F, 0, 1, 0, 2'd0, 32'hFFFF_F00F, 4'hF, 32'h0,         1, 4);
    tbl[14] = mk(1, 0, 3'b000, 32'h0000_0000, 32'h0,         32'h0000_007F, 0, 0, 0, 2'd0, 32'h0000_007F, 4'hF, 32'h0,         1, 3);
    tbl[15] = mk(1, 0, 3'b100, 32'h0000_0102, 32'h0,         32'h12C3_5678, 0, 0, 0, 2'd0, 32'h0000_00C3, 4'hF, 32'h0,         1, 3);
    tbl[16] = mk(1, 0, 3'b010, 32'h0000_0404, 32'h0,         32'h0,         0, -1, 0, 2'd3, 32'h0,        4'hF, 32'h0,         1, 5);
    tbl[17] = mk(0, 1, 3'b100, 32'h0000_0000, 32'h0,         32'h0,         0, 0, 0, 2'd2, 32'h0,         4'h0, 32'h0,         0, 1);
    tbl[18] = mk(1, 0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         0, 0, 0, 2'd2, 32'h0,         4'h0, 32'h0,         0, 1);

    // Reset state: stall must stay low even with a load presented.
    resetn = 1'b0;
    drop_inputs();
    mem_read_en = 1'b1;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    #2;
    cur = -1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_flags", 32'({bus_req, bus_we, load_valid, fault, fault_cause}), 32'd0);
    chk("reset_bus_addr", bus_addr, 32'd0);
    chk("reset_bus_wdata_be", bus_wdata | 32'(bus_be), 32'd0);
    chk("reset_load_data", load_data, 32'd0);
    mem_read_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 19; i++) run_vec(i, tbl[i]);

    // Timeout while waiting for a grant, then a stray response must be ignored.
    run_vec(20, mk(1, 0, 3'b010, 32'h0000_0400, 32'h0, 32'h0, -1, 0, 0, 2'd3, 32'h0, 4'hF, 32'h0, TMO, TMO + 1));
    cur = 21;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("late_rvalid_quiet", 32'({load_valid, fault, stall, bus_req}), 32'd0);
      bus_rvalid = 1'b1; bus_gnt = 1'b1; bus_rdata = 32'h1111_1111;
    end
    @(negedge clk);
    bus_rvalid = 1'b0; bus_gnt = 1'b0;
    chk("late_rvalid_lv", 32'(load_valid), 32'd0);
    chk("late_rvalid_data", load_data, last_load);

    // Reset while in RESP: stall and bus outputs drop in the same cycle.
    cur = 22;
    @(negedge clk);
    mem_read_en = 1'b1; func3 = 3'b010; address = 32'h0000_0500;
    @(negedge clk);
    chk("pre_reset_req", 32'(bus_req), 32'd1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("pre_reset_stall", 32'(stall), 32'd1);
    resetn = 1'b0;
    #1;
    chk("reset_resp_stall", 32'(stall), 32'd0);
    chk("reset_resp_bus", 32'({bus_req, bus_we, load_valid, fault}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Reset while in REQ: the asserted request is withdrawn immediately.
    cur = 23;
    @(negedge clk);
    chk("reset_req_active", 32'(bus_req), 32'd1);
    resetn = 1'b0;
    #1;
    chk("reset_req_drop", 32'({bus_req, stall}), 32'd0);
    chk("reset_req_be", 32'(bus_be), 32'd0);
    drop_inputs();
    last_load = '0;
    @(negedge clk);
    resetn = 1'b1;

    run_vec(24, tbl[0]);
    run_vec(25, tbl[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_sequencer.md
# load_store_sequencer

Multi-cycle sequencer that lets the single-cycle core reach a handshaked data-memory bus. On a load or store decoded by the control unit, it holds the core with `stall`, issues one request/grant transaction, aligns and extends the read data, and reports misalignment, illegal width and bus timeout. It sits between the control unit/ALU outputs and the data-memory port, replacing the zero-latency memory path.

## Interface
- `TIMEOUT`, 255: max cycles spent in REQ+RESP before fault; range 2..255.
- `clk`  in  1  core clock, rising edge.
- `resetn`  in  1  reset; one clock; asynchronous, active-low.
- `mem_read_en`  in  1  load instruction present (load writeback select decoded).
- `data_mem_write`  in  1  store instruction present.
- `func3`  in  3  access width/sign from instruction.
- `address`  in  32  byte address from ALU.
- `store_data`  in  32  rs2 data.
- `stall`  out  1  hold PC, suppress register write.
- `load_data`  out  32  aligned, extended load result.
- `load_valid`  out  1  one-cycle pulse: `load_data` valid, write rd.
- `fault`  out  1  one-cycle pulse: instruction retired without effect.
- `fault_cause`  out  2  1 misaligned, 2 illegal (bad func3 or read+write both high), 3 timeout; 0 otherwise.
- `bus_req`, `bus_we`  out  1  request, write flag.
- `bus_addr`  out  32  word-aligned address (`address[31:2]`, 2'b00).
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_be`  out  4  byte enables.
- `bus_gnt`, `bus_rvalid`  in  1  request accepted; response/write-ack.
- `bus_rdata`  in  32  read word.

## Operation
- States: IDLE, REQ, RESP, DONE, FAULT.
- IDLE: when `mem_read_en|data_mem_write`, `stall`=1 (combinational), check operation: illegal or misaligned -> FAULT; else latch address, width, sign, we, be, wdata -> REQ. No operation -> stay, `stall`=0.
- Misaligned: word with `address[1:0]`≠0; half with `address[0]`≠0. Illegal loads: func3 011/110/111; illegal stores: func3 ≥ 011.
- REQ: `bus_req`=1, bus outputs held constant; `bus_gnt` -> RESP.
- RESP: wait `bus_rvalid`; capture `bus_rdata` -> DONE. rvalid sampled only in RESP.
- DONE: `stall`=0; loads pulse `load_valid`; -> IDLE. Next instruction seen in following IDLE cycle.
- FAULT: `stall`=0, `fault`=1 with cause, no bus activity; -> IDLE.
- Timeout: 8-bit counter cleared in IDLE, +1 each REQ/RESP cycle; on reaching `TIMEOUT` -> FAULT (cause 3), `bus_req` dropped; a late `bus_rvalid` is ignored.
- Store lanes: SB `bus_be`=4'b0001<<addr[1:0], wdata = byte×4; SH 4'b0011<<addr[1:0], wdata = half×2; SW 4'b1111. Loads: `bus_be`=4'b1111.
- Load align: select byte/half by `address[1:0]`; LB/LH sign-extend, LBU/LHU zero-extend, LW pass.
- `bus_gnt` outside REQ and `bus_rvalid` outside RESP ignored.

## Timing
- Reset: state IDLE, counter 0, all outputs 0 (`stall` 0, bus outputs 0) immediately on `resetn` low; reset mid-transaction abandons it with no response handling.
- Minimum load/store: 4 cycles (IDLE detect, REQ with gnt, RESP with rvalid, DONE).
- Fault path: 2 cycles (IDLE detect, FAULT).
- `load_data` is registered and held until next capture; valid only with `load_valid`.
- `bus_*` outputs registered; stable for whole REQ.

## Structure
- Package `lsu_pkg`: state enum, func3 constants (LB..LHU, SB/SH/SW), fault cause codes, `TIMEOUT` default.
- One sub-module: `lsu_load_align` (combinational lane select + extension), instantiated on captured rdata.

## Test plan
- LW addr 0x100, gnt in REQ, rvalid=1 rdata 0xDEADBEEF next cycle -> `bus_addr` 0x100, `bus_be` 1111, DONE `load_data` 0xDEADBEEF, `load_valid` one cycle, `stall` high exactly 3 cycles.
- LB addr 0x103 rdata 0x80000000 -> `load_data` 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 rdata 0xBEEF0000 -> 0x0000BEEF.
- SH addr 0x206 data 0x1234ABCD -> `bus_we`=1, `bus_be` 1100, `bus_wdata` 0xABCDABCD, no `load_valid`.
- LW addr 0x101 -> no `bus_req`, `fault`=1 cause 1 in cycle 2; func3 111 load -> cause 2.
- `TIMEOUT`=4, `bus_gnt` never -> `bus_req` 4 cycles, then `fault` cause 3, `bus_req`=0; later rvalid ignored.
- `resetn` low in RESP -> `stall`, `bus_req` 0 same cycle; after release new LW completes normally.
